conv_tile_scheduler: RTL and testbench

Controller that sequences one CNN layer through a fixed-size systolic array. The layer is a GEMM of K filter rows × (C·wH·wH) reduction × (oH·oH) output columns. The array computes one TM×TP tile per launch, so this block walks the tile grid and launches the array per tile. It then waits for array completion and hands each finished tile to the ofmap writeback stage through a valid/ready handshake. It sits between the layer-level start/done control and the systolic array / ofmap-dearrange datapath.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/conv_tile_scheduler_if.sv | 31 +++
 rtl/tile_counter.sv | 55 +++++
 rtl/conv_tile_scheduler.sv | 100 ++++++++++
 tb/tb_conv_tile_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared scheduler state type and layer-geometry helpers.
// Revision    : 1.0
// ============================================================================
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WB     = 3'd3,
        S_DONE   = 3'd4
    } sched_state_t;

    function automatic int calc_oH(input int ih, input int wh, input int p, input int s);
        return (ih - wh + 2 * p) / s + 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_tile_scheduler_if
// Description : Array-launch and ofmap-writeback signals of the tile scheduler.
// Revision    : 1.0
// ============================================================================
interface conv_tile_scheduler_if #(
    parameter int KW = 4,
    parameter int PW = 7
);
    logic          o_sa_start;
    logic          i_sa_finished;
    logic [KW-1:0] o_k_base;
    logic [KW-1:0] o_k_len;
    logic [PW-1:0] o_p_base;
    logic [PW-1:0] o_p_len;
    logic          o_last_tile;
    logic          o_wb_valid;
    logic          i_wb_ready;

    modport master (
        output o_sa_start, o_k_base, o_k_len, o_p_base, o_p_len, o_last_tile, o_wb_valid,
        input  i_sa_finished, i_wb_ready
    );

    modport slave (
        input  o_sa_start, o_k_base, o_k_len, o_p_base, o_p_len, o_last_tile, o_wb_valid,
        output i_sa_finished, i_wb_ready
    );
endinterface
`default_nettype wire

// File: rtl/tile_counter.sv
`default_nettype none
// ============================================================================
// Module      : tile_counter
// Description : One tile-grid axis: running base, clipped length, last/wrap.
// Revision    : 1.0
// ============================================================================
module tile_counter #(
    parameter int TOTAL = 64,
    parameter int TILE  = 16,
    parameter int W     = 7
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clear,
    input  wire logic         i_step,
    output logic [W-1:0]      o_base,
    output logic [W-1:0]      o_len,
    output logic              o_last,
    output logic              o_wrap
);

    logic [W-1:0] r_base;
    logic [W-1:0] r_len;
    logic [31:0]  w_base_ext;
    logic [31:0]  w_next_base;

    // Remainder is only taken when it is below TILE, so it always fits in W bits.
    function automatic logic [W-1:0] len_at(input logic [31:0] b);
        logic [31:0] rem;
        rem = 32'(TOTAL) - b;
        return (rem < 32'(TILE)) ? rem[W-1:0] : W'(TILE);
    endfunction

    assign w_base_ext  = 32'(r_base);
    assign o_last      = (w_base_ext + 32'(TILE)) >= 32'(TOTAL);
    assign o_wrap      = i_step && o_last;
    assign w_next_base = o_last ? 32'd0 : (w_base_ext + 32'(TILE));
    assign o_base      = r_base;
    assign o_len       = r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
        end else if (i_clear) begin
            r_base <= '0;
            r_len  <= len_at(32'd0);
        end else if (i_step) begin
            r_base <= w_next_base[W-1:0];
            r_len  <= len_at(w_next_base);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_tile_scheduler
// Description : Walks the layer's GEMM tile grid, launching the array per tile
//               and handing each finished tile to ofmap writeback.
// Revision    : 1.0
// ============================================================================
module conv_tile_scheduler
    import cnn_pkg::*;
#(
    parameter int C  = 3,
    parameter int K  = 8,
    parameter int iH = 8,
    parameter int wH = 3,
    parameter int P  = 1,
    parameter int S  = 1,
    parameter int TM = 4,
    parameter int TP = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_start,
    output logic                  o_busy,
    output logic                  o_done,
    conv_tile_scheduler_if.master bus
);

    localparam int oH      = calc_oH(iH, wH, P, S);
    localparam int PT      = oH * oH;
    localparam int KW      = $clog2(K + 1);
    localparam int PW      = $clog2(PT + 1);
    localparam int N_TILES = ceil_div(K, TM) * ceil_div(PT, TP);

    if (C < 1 || K < 1 || S < 1 || TM < 1 || TP < 1 || oH < 1 || N_TILES < 1) begin : g_bad_params
        $error("conv_tile_scheduler: invalid layer or tile geometry");
    end

    sched_state_t r_state;
    logic         r_fin_prev;
    logic         w_fin_rise;
    logic         w_clear;
    logic         w_step;
    logic         w_p_wrap;
    logic         w_k_wrap;
    logic         w_k_last;
    logic         w_p_last;

    assign w_fin_rise = bus.i_sa_finished && !r_fin_prev;
    assign w_clear    = (r_state == S_IDLE) && i_start;
    assign w_step     = (r_state == S_WB) && bus.i_wb_ready;

    // p is the inner axis; its wrap steps k. A k wrap therefore marks the
    // handshake of the final tile of the layer.
    tile_counter #(.TOTAL(PT), .TILE(TP), .W(PW)) u_p_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_step  (w_step),
        .o_base  (bus.o_p_base),
        .o_len   (bus.o_p_len),
        .o_last  (w_p_last),
        .o_wrap  (w_p_wrap)
    );

    tile_counter #(.TOTAL(K), .TILE(TM), .W(KW)) u_k_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_step  (w_p_wrap),
        .o_base  (bus.o_k_base),
        .o_len   (bus.o_k_len),
        .o_last  (w_k_last),
        .o_wrap  (w_k_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fin_prev <= 1'b0;
        end else begin
            r_fin_prev <= bus.i_sa_finished;
            case (r_state)
                S_IDLE:   if (i_start) r_state <= S_LAUNCH;
                S_LAUNCH: r_state <= S_WAIT;
                S_WAIT:   if (w_fin_rise) r_state <= S_WB;
                S_WB:     if (bus.i_wb_ready) r_state <= w_k_wrap ? S_DONE : S_LAUNCH;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign bus.o_sa_start  = (r_state == S_LAUNCH);
    assign bus.o_wb_valid  = (r_state == S_WB);
    assign bus.o_last_tile = (r_state != S_IDLE) && w_k_last && w_p_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_tile_scheduler
// Description : Directed bench over three layer geometries of the scheduler.
// Revision    : 1.0
// ============================================================================
module tb_conv_tile_scheduler;

    typedef struct {
        int kb;
        int kl;
        int pb;
        int pl;
        bit last;
    } tile_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] rdy;
    logic [2:0] fin_man;
    logic [2:0] fin_mod = '0;
    logic [2:0] auto_m;
    wire  [2:0] fin;
    wire  [2:0] busy, done, sa_start, wbv, last;
    wire  [7:0] kb [3];
    wire  [7:0] kl [3];
    wire  [7:0] pb [3];
    wire  [7:0] pl [3];
    int         dly [3];
    int         cnt [3]   = '{0, 0, 0};
    int         n_launch [3] = '{0, 0, 0};
    int         n_checks = 0;
    int         n_errors = 0;
    tile_vec_t  vecs [15];

    always #5 clk = ~clk;

    assign fin = (auto_m & fin_mod) | (~auto_m & fin_man);

    conv_tile_scheduler_if #(.KW(4), .PW(7)) if0 ();
    conv_tile_scheduler_if #(.KW(3), .PW(7)) if1 ();
    conv_tile_scheduler_if #(.KW(3), .PW(3)) if2 ();

    conv_tile_scheduler u0 (
        .clk(clk), .rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]), .bus(if0.master)
    );
    conv_tile_scheduler #(.K(6), .TP(24)) u1 (
        .clk(clk), .rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]), .bus(if1.master)
    );
    conv_tile_scheduler #(.K(4), .iH(4), .wH(3), .P(0)) u2 (
        .clk(clk), .rst(rst), .i_start(start[2]), .o_busy(busy[2]), .o_done(done[2]), .bus(if2.master)
    );

    assign if0.i_sa_finished = fin[0];
    assign if1.i_sa_finished = fin[1];
    assign if2.i_sa_finished = fin[2];
    assign if0.i_wb_ready    = rdy[0];
    assign if1.i_wb_ready    = rdy[1];
    assign if2.i_wb_ready    = rdy[2];
    assign sa_start = {if2.o_sa_start,  if1.o_sa_start,  if0.o_sa_start};
    assign wbv      = {if2.o_wb_valid,  if1.o_wb_valid,  if0.o_wb_valid};
    assign last     = {if2.o_last_tile, if1.o_last_tile, if0.o_last_tile};
    assign kb[0] = 8'(if0.o_k_base);  assign kb[1] = 8'(if1.o_k_base);  assign kb[2] = 8'(if2.o_k_base);
    assign kl[0] = 8'(if0.o_k_len);   assign kl[1] = 8'(if1.o_k_len);   assign kl[2] = 8'(if2.o_k_len);
    assign pb[0] = 8'(if0.o_p_base);  assign pb[1] = 8'(if1.o_p_base);  assign pb[2] = 8'(if2.o_p_base);
    assign pl[0] = 8'(if0.o_p_len);   assign pl[1] = 8'(if1.o_p_len);   assign pl[2] = 8'(if2.o_p_len);

    // Array stand-in: finished rises dly cycles after the launch cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (sa_start[d]) begin
                n_launch[d] = n_launch[d] + 1;
                cnt[d]      = dly[d];
                fin_mod[d]  = 1'b0;
            end else if (cnt[d] > 0) begin
                cnt[d] = cnt[d] - 1;
                if (cnt[d] == 0) fin_mod[d] = 1'b1;
            end
        end
    end

    function automatic logic [32:0] fields(input int d);
        return {kb[d], kl[d], pb[d], pl[d], last[d]};
    endfunction

    function automatic logic [36:0] all_out(input int d);
        return {busy[d], done[d], sa_start[d], wbv[d], fields(d)};
    endfunction

    function automatic logic [32:0] vexp(input tile_vec_t v);
        return {8'(v.kb), 8'(v.kl), 8'(v.pb), 8'(v.pl), v.last};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_layer(input int d, input int first, input int n, output int cyc);
        int t;
        int launches0;
        launches0 = n_launch[d];
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        cyc = 1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!sa_start[d] && t < 40) begin @(negedge clk); t++; cyc++; end
            check($sformatf("dut%0d tile%0d launch", d, i), 64'(sa_start[d]), 64'd1);
            check($sformatf("dut%0d tile%0d fields@launch", d, i), 64'(fields(d)), 64'(vexp(vecs[first + i])));
            t = 0;
            while (!wbv[d] && t < 40) begin @(negedge clk); t++; cyc++; end
            check($sformatf("dut%0d tile%0d wb_valid", d, i), 64'(wbv[d]), 64'd1);
            check($sformatf("dut%0d tile%0d fields@wb", d, i), 64'(fields(d)), 64'(vexp(vecs[first + i])));
            @(negedge clk); cyc++;
        end
        check($sformatf("dut%0d done after last handshake", d), 64'({busy[d], done[d]}), 64'b11);
        @(negedge clk);
        check($sformatf("dut%0d idle after done", d), 64'({busy[d], done[d]}), 64'b00);
        check($sformatf("dut%0d launch count", d), 64'(n_launch[d] - launches0), 64'(n));
    endtask

    initial begin
        int cyc;
        int t;
        int seen;

        // default layer: 2 k-tiles x 4 p-tiles
        vecs[0]  = '{0, 4,  0, 16, 1'b0};
        vecs[1]  = '{0, 4, 16, 16, 1'b0};
        vecs[2]  = '{0, 4, 32, 16, 1'b0};
        vecs[3]  = '{0, 4, 48, 16, 1'b0};
        vecs[4]  = '{4, 4,  0, 16, 1'b0};
        vecs[5]  = '{4, 4, 16, 16, 1'b0};
        vecs[6]  = '{4, 4, 32, 16, 1'b0};
        vecs[7]  = '{4, 4, 48, 16, 1'b1};
        // K=6, TP=24: ragged edges on both axes
        vecs[8]  = '{0, 4,  0, 24, 1'b0};
        vecs[9]  = '{0, 4, 24, 24, 1'b0};
        vecs[10] = '{0, 4, 48, 16, 1'b0};
        vecs[11] = '{4, 2,  0, 24, 1'b0};
        vecs[12] = '{4, 2, 24, 24, 1'b0};
        vecs[13] = '{4, 2, 48, 16, 1'b1};
        // single-tile layer: K=4, PT=4
        vecs[14] = '{0, 4,  0,  4, 1'b1};

        rst = 1'b1; start = '0; rdy = '0; fin_man = '0; auto_m = 3'b111;
        dly[0] = 5; dly[1] = 1; dly[2] = 1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("dut%0d reset outputs", d), 64'(all_out(d)), 64'd0);
        rst = 1'b0;

        rdy = 3'b111;
        run_layer(0, 0, 8, cyc);
        run_layer(1, 8, 6, cyc);
        run_layer(2, 14, 1, cyc);
        check("single-tile done latency", 64'(cyc), 64'd4);

        // writeback backpressure holds the tile
        dly[0] = 1; rdy[0] = 1'b0;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        t = 0;
        while (!wbv[0] && t < 40) begin @(negedge clk); t++; end
        check("bp wb_valid", 64'(wbv[0]), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp hold", 64'({wbv[0], sa_start[0], fields(0)}), 64'({2'b10, vexp(vecs[0])}));
        end
        rdy[0] = 1'b1;
        @(negedge clk);
        check("bp release next tile", 64'({sa_start[0], fields(0)}), 64'({1'b1, vexp(vecs[1])}));
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("bp abort", 64'(all_out(0)), 64'd0);

        // finished already high at launch: only a fresh rising edge counts
        auto_m[0] = 1'b0; fin_man[0] = 1'b1;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        check("level launch", 64'(sa_start[0]), 64'd1);
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (4) begin
            check("level no wb", 64'({busy[0], wbv[0], sa_start[0]}), 64'b100);
            @(negedge clk);
        end
        fin_man[0] = 1'b0;
        @(negedge clk);
        check("level dropped", 64'({busy[0], wbv[0], sa_start[0]}), 64'b100);
        fin_man[0] = 1'b1;
        @(negedge clk);
        check("level re-raise wb", 64'({wbv[0], fields(0)}), 64'({1'b1, vexp(vecs[0])}));
        @(negedge clk);
        check("level next launch", 64'({sa_start[0], fields(0)}), 64'({1'b1, vexp(vecs[1])}));
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        auto_m[0] = 1'b1; fin_man[0] = 1'b0;

        // reset during WAIT of the third tile, then restart
        dly[0] = 5;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        t = 0; seen = 0;
        while (t < 100) begin
            if (sa_start[0]) seen++;
            if (seen == 3) break;
            @(negedge clk); t++;
        end
        check("rst tile3 reached", 64'(seen), 64'd3);
        check("rst tile3 fields", 64'(fields(0)), 64'(vexp(vecs[2])));
        @(negedge clk);
        check("rst tile3 waiting", 64'({busy[0], wbv[0], sa_start[0]}), 64'b100);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("rst outputs cleared", 64'(all_out(0)), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst no done", 64'(all_out(0)), 64'd0);
        end
        run_layer(0, 0, 8, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
